// File: rtl/ack_receiver_pkg.sv
// Shared types and constants for the ACK/NAK response receiver.
package ack_receiver_pkg;

    // Message type codes carried in byte 0 of an ACK/NAK frame.
    localparam logic [7:0] MSG_TYPE_ACK = 8'h00;
    localparam logic [7:0] MSG_TYPE_NAK = 8'h01;

    // Frame parser position within the current frame.
    typedef enum logic [2:0] {
        PS_IDLE,
        PS_EID,
        PS_LEN,
        PS_PAYLOAD,
        PS_DONE,
        PS_SKIP,
        PS_OVERRUN
    } parse_state_e;

    // True when the type byte opens a frame this block understands.
    function automatic logic is_ack_nak_type(input logic [7:0] type_byte);
        return (type_byte == MSG_TYPE_ACK) || (type_byte == MSG_TYPE_NAK);
    endfunction

endpackage

// File: rtl/ack_receiver.sv
// Receive-side ACK/NAK frame parser with an armed response wait and timeout.
// All result pulses are registered and appear the cycle after the frame ends.
module ack_receiver
    import ack_receiver_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(1000000)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] message_data,
    input  logic       message_data_valid,
    input  logic       message_frame_valid,
    input  logic       wait_start,
    input  logic [7:0] wait_eid,
    output logic       busy,
    output logic       ack_received,
    output logic       nak_received,
    output logic       timeout,
    output logic       frame_error,
    output logic       unmatched,
    output logic [7:0] last_eid
);

    localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_CYCLES - TIMER_ONE;

    parse_state_e         state_q,      state_d;
    logic                 is_nak_q,     is_nak_d;
    logic [7:0]           eid_q,        eid_d;
    logic [7:0]           remain_q,     remain_d;
    logic                 busy_q,       busy_d;
    logic [7:0]           exp_eid_q,    exp_eid_d;
    logic [TIMEOUT_W-1:0] timer_q,      timer_d;
    logic                 ack_q,        ack_d;
    logic                 nak_q,        nak_d;
    logic                 timeout_q,    timeout_d;
    logic                 ferr_q,       ferr_d;
    logic                 unmatched_q,  unmatched_d;
    logic [7:0]           last_eid_q,   last_eid_d;

    logic byte_en;
    logic frame_end;
    logic matched;

    assign byte_en   = message_frame_valid && message_data_valid;
    assign frame_end = !message_frame_valid && (state_q != PS_IDLE);

    // State register: parser, arm/timer and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PS_IDLE;
            is_nak_q    <= 1'b0;
            eid_q       <= 8'h00;
            remain_q    <= 8'h00;
            busy_q      <= 1'b0;
            exp_eid_q   <= 8'h00;
            timer_q     <= '0;
            ack_q       <= 1'b0;
            nak_q       <= 1'b0;
            timeout_q   <= 1'b0;
            ferr_q      <= 1'b0;
            unmatched_q <= 1'b0;
            last_eid_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            is_nak_q    <= is_nak_d;
            eid_q       <= eid_d;
            remain_q    <= remain_d;
            busy_q      <= busy_d;
            exp_eid_q   <= exp_eid_d;
            timer_q     <= timer_d;
            ack_q       <= ack_d;
            nak_q       <= nak_d;
            timeout_q   <= timeout_d;
            ferr_q      <= ferr_d;
            unmatched_q <= unmatched_d;
            last_eid_q  <= last_eid_d;
        end
    end

    // Next-state: frame parsing, end-of-frame evaluation, then timer and re-arm.
    always_comb begin
        state_d     = state_q;
        is_nak_d    = is_nak_q;
        eid_d       = eid_q;
        remain_d    = remain_q;
        busy_d      = busy_q;
        exp_eid_d   = exp_eid_q;
        timer_d     = timer_q;
        last_eid_d  = last_eid_q;
        ack_d       = 1'b0;
        nak_d       = 1'b0;
        timeout_d   = 1'b0;
        ferr_d      = 1'b0;
        unmatched_d = 1'b0;
        matched     = 1'b0;

        if (frame_end) begin
            // Evaluation uses the arm state as it stood before this edge.
            state_d = PS_IDLE;
            case (state_q)
                PS_DONE: begin
                    last_eid_d = eid_q;
                    if (busy_q && (eid_q == exp_eid_q)) begin
                        matched = 1'b1;
                        ack_d   = !is_nak_q;
                        nak_d   = is_nak_q;
                    end else begin
                        unmatched_d = 1'b1;
                    end
                end
                PS_EID, PS_LEN, PS_PAYLOAD, PS_OVERRUN: ferr_d = 1'b1;
                default: ;
            endcase
        end else if (byte_en) begin
            case (state_q)
                PS_IDLE: begin
                    if (is_ack_nak_type(message_data)) begin
                        is_nak_d = (message_data == MSG_TYPE_NAK);
                        state_d  = PS_EID;
                    end else begin
                        state_d = PS_SKIP;
                    end
                end
                PS_EID: begin
                    eid_d   = message_data;
                    state_d = PS_LEN;
                end
                PS_LEN: begin
                    remain_d = message_data;
                    state_d  = (message_data == 8'h00) ? PS_DONE : PS_PAYLOAD;
                end
                PS_PAYLOAD: begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = PS_DONE;
                    end
                end
                PS_DONE: state_d = PS_OVERRUN;
                default: ;
            endcase
        end

        // A match on the expiry edge wins over the timeout.
        if (matched) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            if (timer_q == TIMER_LAST) begin
                timeout_d = 1'b1;
                busy_d    = 1'b0;
            end else begin
                timer_d = timer_q + TIMER_ONE;
            end
        end

        // Arming replaces any pending wait without reporting it.
        if (wait_start) begin
            busy_d    = 1'b1;
            timer_d   = '0;
            exp_eid_d = wait_eid;
            timeout_d = 1'b0;
        end
    end

    assign busy         = busy_q;
    assign ack_received = ack_q;
    assign nak_received = nak_q;
    assign timeout      = timeout_q;
    assign frame_error  = ferr_q;
    assign unmatched    = unmatched_q;
    assign last_eid     = last_eid_q;

endmodule

// File: tb/tb_ack_receiver.sv
// Bench for ack_receiver: directed scenarios followed by random frames,
// every cycle checked against a frame-level reference model.
module tb_ack_receiver;

    localparam int TC = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] message_data = 8'h00;
    logic       message_data_valid = 1'b0;
    logic       message_frame_valid = 1'b0;
    logic       wait_start = 1'b0;
    logic [7:0] wait_eid = 8'h00;
    logic       busy, ack_received, nak_received, timeout, frame_error, unmatched;
    logic [7:0] last_eid;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] fq[$];
    logic       m_busy = 1'b0;
    logic [7:0] m_exp = 8'h00;
    int         m_age = 0;
    logic [7:0] m_last = 8'h00;
    logic       m_ack = 1'b0, m_nak = 1'b0, m_to = 1'b0, m_fe = 1'b0, m_um = 1'b0;

    ack_receiver #(.TIMEOUT_W(24), .TIMEOUT_CYCLES(24'(TC))) dut (
        .clk                 (clk),
        .reset               (reset),
        .message_data        (message_data),
        .message_data_valid  (message_data_valid),
        .message_frame_valid (message_frame_valid),
        .wait_start          (wait_start),
        .wait_eid            (wait_eid),
        .busy                (busy),
        .ack_received        (ack_received),
        .nak_received        (nak_received),
        .timeout             (timeout),
        .frame_error         (frame_error),
        .unmatched           (unmatched),
        .last_eid            (last_eid)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("busy",        32'(busy),         32'(m_busy));
        check("ack",         32'(ack_received), 32'(m_ack));
        check("nak",         32'(nak_received), 32'(m_nak));
        check("timeout",     32'(timeout),      32'(m_to));
        check("frame_error", 32'(frame_error),  32'(m_fe));
        check("unmatched",   32'(unmatched),    32'(m_um));
        check("last_eid",    32'(last_eid),     32'(m_last));
    endtask

    task automatic model_reset();
        fq.delete();
        m_busy = 0; m_exp = 0; m_age = 0; m_last = 0;
        m_ack = 0; m_nak = 0; m_to = 0; m_fe = 0; m_um = 0;
    endtask

    // One clock edge of the reference behaviour, driven by the current inputs.
    task automatic model_edge();
        logic matched;
        matched = 0;
        m_ack = 0; m_nak = 0; m_to = 0; m_fe = 0; m_um = 0;
        if (!message_frame_valid && fq.size() > 0) begin
            if (fq[0] > 8'h01) begin
                $display("frame bytes=%0d type=%0h -> ignored", fq.size(), fq[0]);
            end else if (fq.size() >= 3 && fq.size() == 3 + int'(fq[2])) begin
                m_last = fq[1];
                if (m_busy && fq[1] == m_exp) begin
                    matched = 1;
                    m_busy = 0;
                    if (fq[0] == 8'h00) m_ack = 1; else m_nak = 1;
                end else begin
                    m_um = 1;
                end
                $display("frame bytes=%0d type=%0h eid=%0h -> %s", fq.size(), fq[0], fq[1],
                         matched ? (m_ack ? "ack" : "nak") : "unmatched");
            end else begin
                m_fe = 1;
                $display("frame bytes=%0d type=%0h -> frame_error", fq.size(), fq[0]);
            end
            fq.delete();
        end else if (message_frame_valid && message_data_valid) begin
            fq.push_back(message_data);
        end
        if (m_busy && !matched) begin
            m_age++;
            if (m_age == TC) begin
                m_to = 1;
                m_busy = 0;
            end
        end
        if (wait_start) begin
            m_busy = 1; m_age = 0; m_exp = wait_eid; m_to = 0;
        end
    endtask

    task automatic step(input logic fv, input logic dv, input logic [7:0] d,
                        input logic ws, input logic [7:0] we);
        message_frame_valid = fv;
        message_data_valid  = dv;
        message_data        = d;
        wait_start          = ws;
        wait_eid            = we;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic arm(input logic [7:0] e);
        step(0, 0, 8'h00, 1, e);
    endtask

    task automatic put_byte(input logic [7:0] b);
        step(1, 1, b, 0, 8'h00);
    endtask

    // Sends n bytes, with an optional data_valid gap after byte gap_pos, then ends the frame.
    task automatic send_frame(input logic [7:0] b[16], input int n, input int gap_pos, input int gap_len);
        for (int i = 0; i < n; i++) begin
            put_byte(b[i]);
            if (i == gap_pos)
                for (int g = 0; g < gap_len; g++) step(1, 0, 8'hEE, 0, 8'h00);
        end
        step(0, 0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] f[16];

        // Reset state
        #1;
        model_reset();
        check_all();
        idle(2);
        #2 reset = 1'b1;
        idle(2);

        // Matching ACK
        arm(8'h5A);
        f[0] = 8'h00; f[1] = 8'h5A; f[2] = 8'h00;
        send_frame(f, 3, -1, 0);
        check("loop_ack", 32'(ack_received), 32'd1);
        check("loop_last_eid", 32'(last_eid), 32'h5A);
        check("loop_busy", 32'(busy), 32'd0);
        idle(1);

        // NAK with a stall after the type byte
        arm(8'h33);
        f[0] = 8'h01; f[1] = 8'h33; f[2] = 8'h00;
        send_frame(f, 3, 0, 2);
        check("gap_nak", 32'(nak_received), 32'd1);
        check("gap_no_ferr", 32'(frame_error), 32'd0);
        idle(1);

        // Wrong EID then matching frame with payload
        arm(8'h10);
        f[0] = 8'h00; f[1] = 8'h11; f[2] = 8'h00;
        send_frame(f, 3, -1, 0);
        check("um_pulse", 32'(unmatched), 32'd1);
        check("um_busy", 32'(busy), 32'd1);
        f[0] = 8'h00; f[1] = 8'h10; f[2] = 8'h03; f[3] = 8'hAA; f[4] = 8'hBB; f[5] = 8'hCC;
        send_frame(f, 6, -1, 0);
        check("pl_ack", 32'(ack_received), 32'd1);
        idle(2);

        // Timeout exactly TC cycles after the arm edge
        arm(8'h77);
        idle(TC - 1);
        check("to_early", 32'(timeout), 32'd0);
        idle(1);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        idle(1);

        // Matching frame ending on the expiry edge
        arm(8'h66);
        idle(TC - 4);
        f[0] = 8'h00; f[1] = 8'h66; f[2] = 8'h00;
        send_frame(f, 3, -1, 0);
        check("race_ack", 32'(ack_received), 32'd1);
        check("race_no_to", 32'(timeout), 32'd0);
        idle(1);

        // Short, long and foreign-type frames
        arm(8'h21);
        f[0] = 8'h00; f[1] = 8'h22;
        send_frame(f, 2, -1, 0);
        check("short_ferr", 32'(frame_error), 32'd1);
        check("short_busy", 32'(busy), 32'd1);
        f[0] = 8'h00; f[1] = 8'h22; f[2] = 8'h00; f[3] = 8'hFF;
        send_frame(f, 4, -1, 0);
        check("long_ferr", 32'(frame_error), 32'd1);
        check("long_busy", 32'(busy), 32'd1);
        f[0] = 8'h07; f[1] = 8'h21; f[2] = 8'h00;
        send_frame(f, 3, -1, 0);
        check("skip_ferr", 32'(frame_error), 32'd0);
        check("skip_um", 32'(unmatched), 32'd0);
        idle(TC);

        // Reset in the middle of a NAK payload
        arm(8'h44);
        put_byte(8'h01); put_byte(8'h44); put_byte(8'h04); put_byte(8'hAA);
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        check("rst_busy", 32'(busy), 32'd0);
        #1 reset = 1'b1;
        put_byte(8'h01); put_byte(8'h44); put_byte(8'h09);
        step(0, 0, 8'h00, 0, 8'h00);
        check("rst_ferr", 32'(frame_error), 32'd1);
        check("rst_no_nak", 32'(nak_received), 32'd0);
        idle(1);

        // Random frames, arms and stalls
        for (int n = 0; n < 300; n++) begin
            int len, nb, r;
            logic [7:0] eids[4];
            eids[0] = 8'h5A; eids[1] = 8'h10; eids[2] = 8'h33; eids[3] = 8'h00;
            if ($urandom_range(0, 2) == 0) arm(eids[$urandom_range(0, 3)]);
            len = $urandom_range(0, 5);
            r = $urandom_range(0, 9);
            f[0] = (r == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
            f[1] = eids[$urandom_range(0, 3)];
            f[2] = 8'(len);
            for (int i = 3; i < 16; i++) f[i] = 8'($urandom);
            nb = 3 + len;
            r = $urandom_range(0, 9);
            if (r == 0) nb = $urandom_range(1, nb);
            else if (r == 1) nb = nb + $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                step(1, 1, f[i], ($urandom_range(0, 40) == 0), eids[$urandom_range(0, 3)]);
                if ($urandom_range(0, 4) == 0) step(1, 0, 8'($urandom), 0, 8'h00);
            end
            step(0, 0, 8'h00, ($urandom_range(0, 20) == 0), eids[$urandom_range(0, 3)]);
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, TC + 2));
        end

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ack_receiver.md
Name: ack_receiver

Overview:
Receive-side counterpart of the ICE ACK/NAK message stream.
- Parses frames on a message_data / message_data_valid / message_frame_valid byte interface.
- Frame format: byte0 = type (0x00 ACK, 0x01 NAK), byte1 = EID, byte2 = payload length, then length payload bytes.
- The host-command path arms the block with an expected EID. The block reports ACK, NAK, timeout, malformed frame or unmatched response as single-cycle pulses.

Parameters:
- TIMEOUT_W, 24, width of the response timeout counter.
- TIMEOUT_CYCLES, 24'd1000000, clock cycles allowed between arm and a matching response.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- message_data  input  8  received byte.
- message_data_valid  input  1  message_data holds a byte this cycle; meaningful only while message_frame_valid=1.
- message_frame_valid  input  1  high for the whole frame; its falling edge ends the frame.
- wait_start  input  1  one-cycle pulse that arms a response wait.
- wait_eid  input  8  expected EID, sampled when wait_start=1.
- busy  output  1  armed and waiting.
- ack_received  output  1  one-cycle pulse: matching ACK frame.
- nak_received  output  1  one-cycle pulse: matching NAK frame.
- timeout  output  1  one-cycle pulse: wait expired.
- frame_error  output  1  one-cycle pulse: malformed ACK/NAK frame.
- unmatched  output  1  one-cycle pulse: well-formed ACK/NAK frame while not armed, or with a different EID.
- last_eid  output  8  EID of the most recent well-formed ACK/NAK frame.

Behaviour:
- Reset: all outputs 0, last_eid=8'h00, parser in IDLE, disarmed, timer 0.
- All outputs are registered.
- A byte is consumed on any edge where message_frame_valid=1 and message_data_valid=1. Gaps with data_valid=0 inside a frame are stalls.
- Parser states and transitions:
  - IDLE: first byte goes to TYPE handling. Type 0x00 or 0x01 is latched, next state EID. Any other type goes to SKIP.
  - EID: byte latched, next state LEN.
  - LEN: byte latched as remaining count. Zero goes to DONE; nonzero goes to PAYLOAD.
  - PAYLOAD: decrements remaining count per byte. Reaching 0 goes to DONE. Payload contents are discarded.
  - DONE: any further byte goes to OVERRUN.
  - SKIP and OVERRUN: absorb bytes until the frame ends.
- Frame end is the first edge sampling message_frame_valid=0 while the parser is not IDLE. On that edge the block returns to IDLE and registers the result, so pulses are visible the cycle after frame_valid falls:
  - From DONE: last_eid updated to the latched EID.
    - If armed and EID == expected: ack_received or nak_received per type, then disarm.
    - Otherwise: unmatched.
  - From EID, LEN, PAYLOAD or OVERRUN (short or long frame): frame_error. Arm state unchanged.
  - From SKIP: no pulse.
  - Frame with frame_valid high but no bytes: ignored.
- Back-to-back frames: frame_valid must be low for at least one cycle between frames. A new frame may start on the cycle immediately after the end cycle.
- Timer and arming:
  - wait_start loads the expected EID, clears the timer and sets busy on the next edge. This applies even while busy (re-arm; the old wait is dropped silently).
  - While busy the timer increments each cycle. When it equals TIMEOUT_CYCLES-1, timeout pulses and busy clears.
  - Matched result and timeout on the same edge: the match wins; no timeout pulse.
  - wait_start on the same edge as a frame end: the frame is evaluated against the pre-arm state, and the new arm takes effect.
- Reset mid-frame: parser returns to IDLE. Remaining bytes of the interrupted frame are parsed as a fresh frame starting from the next byte. A short frame then reports frame_error; this is accepted behaviour.
- Width rules:
  - Length is 8-bit unsigned, so the maximum frame is 258 bytes.
  - Timer compare is unsigned on TIMEOUT_W bits. TIMEOUT_CYCLES=0 is illegal.

Decomposition:
- ACK/NAK type codes (8'h00, 8'h01) are added as defines in include/ice_def.v. The generator and the receiver share them, together with `SD for registered assignments.
- A single module. The timeout counter is small enough to stay inline; no sub-module.

Test Plan:
- Loopback from ack_generator, armed wait_eid=8'h5A, generate_ack with eid 8'h5A -> ack_received one cycle after frame_valid falls; last_eid=8'h5A; busy=0.
- Armed 8'h33, NAK frame {01,33,00} with a 2-cycle data_valid gap after byte0 -> nak_received once; no frame_error.
- Armed 8'h10, ACK frame with EID 8'h11 -> unmatched; busy stays 1. Then {00,10,03,AA,BB,CC} -> ack_received.
- TIMEOUT_CYCLES=16, arm, no frames -> timeout pulse exactly 16 cycles after arm edge; busy=0. Matching frame ending on the timeout edge -> ack_received only.
- Frames {00,22} (short) and {00,22,00,FF} (long) -> frame_error each; arm state unchanged. Frame {07,..} -> no pulse.
- reset asserted low mid-payload of {01,44,04,...} -> all outputs 0 immediately. Remaining bytes -> frame_error at frame end, no nak_received.
